// File: rtl/game_pkg.sv
// Shared encodings for the car game: sequencer states, row-source mux codes and
// default per-level move dividers for a 50 MHz clock.
package game_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] MUX_HOLD = 2'b00;
  localparam logic [1:0] MUX_PREV = 2'b01;
  localparam logic [1:0] MUX_NEW  = 2'b10;

  localparam int LVL1_DIV_DEFAULT = 25_000_000;
  localparam int LVL2_DIV_DEFAULT = 12_500_000;
  localparam int LVL3_DIV_DEFAULT = 6_250_000;

endpackage

// File: rtl/level_prescaler.sv
// Level-dependent down-counter: load picks the divider for the current level,
// expire flags the last counting cycle of a move period.
module level_prescaler
  import game_pkg::*;
#(
  parameter int DIV_WIDTH = 26,
  parameter int LVL1_DIV  = LVL1_DIV_DEFAULT,
  parameter int LVL2_DIV  = LVL2_DIV_DEFAULT,
  parameter int LVL3_DIV  = LVL3_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       load,
  input  logic       enable,
  input  logic       clear,
  output logic       expire
);

  logic [DIV_WIDTH-1:0] count_reg;
  logic [DIV_WIDTH-1:0] reload;

  // Level 0 is treated as level 1.
  always_comb begin
    case (level)
      2'd2:    reload = DIV_WIDTH'(LVL2_DIV - 1);
      2'd3:    reload = DIV_WIDTH'(LVL3_DIV - 1);
      default: reload = DIV_WIDTH'(LVL1_DIV - 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= reload;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = enable && (count_reg == '0);

endmodule

// File: rtl/road_row_sequencer.sv
// Road-row sweep scheduler: after each prescaler expiry, strobes the row
// registers top-down so the road scrolls one row and row 0 takes a new pattern.
module road_row_sequencer
  import game_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int DIV_WIDTH = 26,
  parameter int LVL1_DIV  = LVL1_DIV_DEFAULT,
  parameter int LVL2_DIV  = LVL2_DIV_DEFAULT,
  parameter int LVL3_DIV  = LVL3_DIV_DEFAULT
) (
  input  logic            SC_STATEMACHINE_GENERAL_CLOCK_50,
  input  logic            SC_STATEMACHINE_GENERAL_RESET_InHigh,
  input  logic            enable_InHigh,
  input  logic [1:0]      level_InBUS,
  input  logic            clear_InLow,
  output logic            tick_OutHigh,
  output logic            busy_OutHigh,
  output logic            done_OutHigh,
  output logic [ROWS-1:0] regLoad_OutLowBUS,
  output logic [1:0]      muxSel_OutBUS,
  output logic [3:0]      rowIndex_OutBUS,
  output logic [7:0]      sweepCount_OutBUS
);

  localparam logic [3:0] ROW_TOP = 4'(ROWS - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] row_reg, row_next;
  logic [7:0] sweeps_reg, sweeps_next;
  logic       expire;
  logic       in_count;
  logic       in_load;
  logic       pre_load;
  logic       pre_clear;

  assign in_count  = (state_reg == ST_COUNT);
  assign in_load   = (state_reg == ST_LOAD);
  // Level is captured only when a counting period starts.
  assign pre_load  = enable_InHigh && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign pre_clear = in_count && !enable_InHigh;

  level_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .LVL1_DIV  (LVL1_DIV),
    .LVL2_DIV  (LVL2_DIV),
    .LVL3_DIV  (LVL3_DIV)
  ) u_prescaler (
    .clk    (SC_STATEMACHINE_GENERAL_CLOCK_50),
    .rst    (SC_STATEMACHINE_GENERAL_RESET_InHigh),
    .level  (level_InBUS),
    .load   (pre_load),
    .enable (in_count),
    .clear  (pre_clear),
    .expire (expire)
  );

  always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
      state_reg  <= ST_IDLE;
      row_reg    <= '0;
      sweeps_reg <= '0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      sweeps_reg <= sweeps_next;
    end
  end

  // Expiry wins over a simultaneous enable drop; once LOAD starts the sweep always completes.
  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    sweeps_next = sweeps_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable_InHigh) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (expire) begin
          state_next = ST_LOAD;
          row_next   = ROW_TOP;
        end else if (!enable_InHigh) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (row_reg == 4'd0) state_next = ST_SETTLE;
        else                 row_next   = row_reg - 4'd1;
      end
      ST_SETTLE: state_next = ST_DONE;
      ST_DONE: begin
        state_next = enable_InHigh ? ST_COUNT : ST_IDLE;
        if (sweeps_reg != 8'hFF) sweeps_next = sweeps_reg + 8'd1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!clear_InLow) sweeps_next = '0;
  end

  always_comb begin
    tick_OutHigh      = expire;
    busy_OutHigh      = (state_reg == ST_LOAD) || (state_reg == ST_SETTLE) || (state_reg == ST_DONE);
    done_OutHigh      = (state_reg == ST_DONE);
    sweepCount_OutBUS = sweeps_reg;
    muxSel_OutBUS     = MUX_HOLD;
    rowIndex_OutBUS   = 4'd0;
    if (in_load) begin
      rowIndex_OutBUS = row_reg;
      muxSel_OutBUS   = (row_reg == 4'd0) ? MUX_NEW : MUX_PREV;
    end
  end

  // Strobes decode from state so an async reset releases them without a clock edge.
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_strobe
      assign regLoad_OutLowBUS[gi] = !(in_load && (row_reg == 4'(gi)));
    end
  endgenerate

endmodule

// File: doc/road_row_sequencer.md
Name: road_row_sequencer

Overview:
- Timing and load scheduler for the road-row register bank of the two-player car game.
- Runs a level-dependent prescaler. On each expiry it performs one top-down sweep of the ROWS row registers, so every row shifts down by one and row 0 takes the new car pattern.
- Sweep driven by one-hot active-low load strobes plus a shared source-mux select; signals sweep completion to the general state machine.

Parameters:
ROWS, 8, number of row registers swept (2..16)
DIV_WIDTH, 26, prescaler counter width
LVL1_DIV, 25000000, clocks per move at level 1
LVL2_DIV, 12500000, clocks per move at level 2
LVL3_DIV, 6250000, clocks per move at level 3

Ports:
SC_STATEMACHINE_GENERAL_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINE_GENERAL_RESET_InHigh  in  1  async active-high reset
enable_InHigh  in  1  game running (NIVEL/esperar phases)
level_InBUS  in  2  level 1..3; 0 treated as 1
clear_InLow  in  1  sync clear of sweep counter
tick_OutHigh  out  1  one-cycle pulse at prescaler expiry
busy_OutHigh  out  1  high in LOAD, SETTLE, DONE
done_OutHigh  out  1  one-cycle pulse after sweep
regLoad_OutLowBUS  out  ROWS  one-hot active-low row load strobes
muxSel_OutBUS  out  2  row source: 00 hold, 01 previous row, 10 new pattern
rowIndex_OutBUS  out  4  row currently loaded
sweepCount_OutBUS  out  8  completed sweeps, saturating

Behaviour:
- Reset: already decided, reset SC_STATEMACHINE_GENERAL_RESET_InHigh, asynchronous, active-high; clock SC_STATEMACHINE_GENERAL_CLOCK_50.
- On reset: state IDLE, prescaler 0, regLoad all 1s, muxSel 00, rowIndex 0, tick/busy/done 0, sweepCount 0. Strobes go inactive immediately, without waiting for a clock edge.
- States: IDLE, COUNT, LOAD, SETTLE, DONE.
- IDLE: enable=1 → COUNT; prescaler loaded with DIV-1 for the current level.
- COUNT: prescaler decrements each cycle.
  - When it equals 0: tick=1 that cycle → LOAD with r=ROWS-1.
  - enable=0 → IDLE next cycle, no tick, prescaler cleared.
- LOAD: one row per cycle, r = ROWS-1 down to 0.
  - regLoad[r]=0, all other strobes 1; rowIndex=r.
  - muxSel=01 for r>0, 10 for r=0.
  - r=0 → SETTLE.
  - Top-down order guarantees row r captures the old contents of row r-1.
- SETTLE: one cycle, all strobes 1, muxSel 00 → DONE.
- DONE: done=1 for one cycle; sweepCount increments, saturating at 255.
  - enable=1 → COUNT, reloading the prescaler with the current level's divider.
  - enable=0 → IDLE.
- Period in steady state: DIV + ROWS + 2 cycles.
- Level is sampled only at COUNT entry. A change mid-count takes effect from the next period.
- enable=0 during LOAD/SETTLE does not abort. The sweep always completes, because partial sweeps corrupt the road.
- clear_InLow=0 sets sweepCount to 0 next edge. Clear has priority over a simultaneous DONE increment.
- Outside LOAD: muxSel 00, all strobes 1.
- Unused rowIndex bits are 0 when ROWS<16.
- All outputs are registered or state-decoded. No combinational input-to-output paths.

Decomposition:
- Shared package `game_pkg`:
  - state encoding localparams (IDLE..DONE)
  - mux select codes (HOLD=00, PREV=01, NEW=10)
  - default level divider constants
- One natural sub-module: `level_prescaler`. It takes level and load/enable and outputs the expiry pulse.

Test Plan:
1. Test parameter set for all scenarios: ROWS=8, LVL1_DIV=4, LVL2_DIV=3, LVL3_DIV=2.
   - Reset asserted with no clock → regLoad=8'hFF, busy=0, tick=0, done=0, sweepCount=0.
2. enable=1, level=1 → tick on the 4th COUNT cycle.
   - Next 8 cycles: regLoad 7F,BF,DF,EF,F7,FB,FD,FE; muxSel 01×7 then 10.
   - Then one SETTLE cycle, done pulse, sweepCount=1.
   - Next tick 14 cycles after the first.
3. level changed 1→3 mid-count → current period remains 4. Next period is 2 (tick spacing 12). level=0 → spacing 14.
4. enable dropped in LOAD at r=4 → rows 3..0 still strobed, done pulses, then IDLE.
   - enable dropped in COUNT → IDLE next cycle, no tick, no strobe.
5. Async reset mid-LOAD (regLoad=EF) → regLoad=FF and busy=0 before the next edge. After release, IDLE.
6. clear_InLow=0 in the same cycle as done → sweepCount=0.
   - Force 255 sweeps → sweepCount holds at 255 on the 256th.
